// File: rtl/mvm_pkg.sv
// mvm_pkg: shared widths and datapath types for the matrix-vector datapath
package mvm_pkg;
  localparam int IWIDTH = 8;
  localparam int LANES = 4;
  localparam int OWIDTH = 32;
  localparam int SUMW = 2 * IWIDTH + $clog2(LANES);
  typedef logic signed [IWIDTH-1:0] elem_t;
  typedef logic signed [2*IWIDTH-1:0] prod_t;
  typedef logic signed [SUMW-1:0] sum_t;
  typedef logic signed [OWIDTH-1:0] acc_t;
  typedef logic [LANES*IWIDTH-1:0] word_t;
  typedef struct packed {
    logic valid;
    logic first;
    logic last;
  } flags_t;
endpackage

// File: rtl/dot_accum_if.sv
// dot_accum_if: beat input and row result bundle of the dot product accumulator
interface dot_accum_if;
  import mvm_pkg::*;
  logic ivalid;
  word_t vec_data;
  word_t mat_data;
  logic accum_first;
  logic accum_last;
  acc_t result;
  logic ovalid;
  modport master (
    output ivalid, vec_data, mat_data, accum_first, accum_last,
    input result, ovalid
  );
  modport slave (
    input ivalid, vec_data, mat_data, accum_first, accum_last,
    output result, ovalid
  );
endinterface

// File: rtl/dot_reduce.sv
// dot_reduce: S1 input register, S2 lane products, S3 summed products with flags carried alongside
module dot_reduce
  import mvm_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  flags_t flags_i,
  input  word_t  vec_i,
  input  word_t  mat_i,
  output flags_t flags_o,
  output acc_t   sum_o
);
  flags_t f1_q, f2_q, f3_q, f1_d;
  word_t vec_q, mat_q;
  prod_t prod_q [LANES];
  prod_t prod_d [LANES];
  acc_t sum_q, sum_d;
  sum_t tree;
  assign f1_d = flags_i.valid ? flags_i : '0;
  // lane unpack, signed multiply and sign-extended reduction of the products
  always_comb begin
    for (int i = 0; i < LANES; i++)
      prod_d[i] = prod_t'(elem_t'(vec_q[i*IWIDTH +: IWIDTH])) * prod_t'(elem_t'(mat_q[i*IWIDTH +: IWIDTH]));
    tree = '0;
    for (int i = 0; i < LANES; i++)
      tree = tree + sum_t'(prod_q[i]);
    sum_d = acc_t'(tree);
  end
  // three pipeline registers; flags only travel with a valid beat
  always_ff @(posedge clk) begin
    if (!rst) begin
      {f1_q, f2_q, f3_q} <= '0;
      vec_q <= '0;
      mat_q <= '0;
      for (int i = 0; i < LANES; i++) prod_q[i] <= '0;
      sum_q <= '0;
    end else begin
      f1_q <= f1_d;
      f2_q <= f1_q;
      f3_q <= f2_q;
      vec_q <= vec_i;
      mat_q <= mat_i;
      for (int i = 0; i < LANES; i++) prod_q[i] <= prod_d[i];
      sum_q <= sum_d;
    end
  end
  assign flags_o = f3_q;
  assign sum_o = sum_q;
endmodule

// File: rtl/dot_accum.sv
// dot_accum: accumulates per-beat dot products over a row and emits one result per row
module dot_accum
  import mvm_pkg::*;
(
  input logic clk,
  input logic rst,
  dot_accum_if.slave bus
);
  flags_t in_flags, s3;
  acc_t sum, acc_q, acc_d, res_q, res_d;
  logic ov_q, ov_d;
  assign in_flags = '{valid: bus.ivalid, first: bus.accum_first, last: bus.accum_last};
  dot_reduce u_reduce (
    .clk     (clk),
    .rst     (rst),
    .flags_i (in_flags),
    .vec_i   (bus.vec_data),
    .mat_i   (bus.mat_data),
    .flags_o (s3),
    .sum_o   (sum)
  );
  // first restarts the row, any other valid beat adds on; last publishes the updated total
  always_comb begin
    acc_d = s3.valid ? (s3.first ? sum : acc_q + sum) : acc_q;
    ov_d = s3.valid && s3.last;
    res_d = ov_d ? acc_d : res_q;
  end
  // accumulator and output register
  always_ff @(posedge clk) begin
    if (!rst) begin
      acc_q <= '0;
      res_q <= '0;
      ov_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      res_q <= res_d;
      ov_q <= ov_d;
    end
  end
  assign bus.result = res_q;
  assign bus.ovalid = ov_q;
endmodule

// File: tb/tb_dot_accum.sv
// tb_dot_accum: randomized and directed checks of dot_accum against a row-level model
module tb_dot_accum;
  import mvm_pkg::*;
  typedef struct {
    int due;
    logic signed [31:0] val;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int cyc = 0;
  int checks = 0;
  int passes = 0;
  logic armed = 1'b0;
  logic signed [31:0] acc_m = 0;
  logic signed [31:0] last_res = 0;
  exp_t q[$];
  dot_accum_if bus ();
  dot_accum dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
  endtask
  function automatic logic signed [31:0] dot(input word_t v, input word_t m);
    int s = 0;
    for (int i = 0; i < 4; i++) s += $signed(v[i*8 +: 8]) * $signed(m[i*8 +: 8]);
    return s;
  endfunction
  function automatic word_t pack(input int a, input int b, input int c, input int d);
    logic [7:0] l0 = a[7:0];
    logic [7:0] l1 = b[7:0];
    logic [7:0] l2 = c[7:0];
    logic [7:0] l3 = d[7:0];
    return {l3, l2, l1, l0};
  endfunction
  task automatic drive(input logic r, input logic v, input logic f, input logic l, input word_t vw, input word_t mw);
    logic signed [31:0] d;
    @(posedge clk);
    #1;
    rst = r;
    bus.ivalid = v;
    bus.accum_first = f;
    bus.accum_last = l;
    bus.vec_data = vw;
    bus.mat_data = mw;
    if (!r) begin
      while (q.size() > 0 && q[$].due > cyc) void'(q.pop_back());
      acc_m = 0;
    end else if (v) begin
      d = dot(vw, mw);
      acc_m = f ? d : acc_m + d;
      if (l) q.push_back('{cyc + 4, acc_m});
    end
  endtask
  task automatic idle();
    drive(1'b1, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), word_t'($urandom), word_t'($urandom));
  endtask
  task automatic lit(input string name, input logic ov, input logic signed [31:0] val);
    @(negedge clk);
    chk({name, "_ovalid"}, 32'(ov), 32'(bus.ovalid));
    chk({name, "_result"}, bus.result, val);
  endtask
  // row-level reference: ovalid exactly when a row's total is due, result held otherwise
  always @(negedge clk) begin
    logic exp_ov;
    exp_ov = q.size() > 0 && q[0].due == cyc;
    if (exp_ov) begin
      last_res = q[0].val;
      void'(q.pop_front());
    end
    if (armed) begin
      chk("ovalid", 32'(bus.ovalid), 32'(exp_ov));
      chk("result", bus.result, last_res);
    end
    if (!rst) begin
      armed = 1'b1;
      last_res = 0;
    end
  end
  initial begin
    word_t ones = pack(1, 1, 1, 1);
    bus.ivalid = 1'b0;
    bus.accum_first = 1'b0;
    bus.accum_last = 1'b0;
    bus.vec_data = '0;
    bus.mat_data = '0;
    repeat (3) drive(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    lit("reset", 1'b0, 0);
    drive(1'b1, 1'b1, 1'b1, 1'b1, pack(1, 2, 3, 4), pack(5, 6, 7, 8));
    repeat (4) idle();
    lit("single", 1'b1, 70);
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, i == 0, i == 2, ones, ones);
    repeat (4) idle();
    lit("three_word", 1'b1, 12);
    drive(1'b1, 1'b1, 1'b1, 1'b1, pack(-128, -128, -128, -128), pack(127, 127, 127, 127));
    repeat (4) idle();
    lit("signed", 1'b1, 32'hFFFF0200);
    drive(1'b1, 1'b1, 1'b1, 1'b0, pack(2, 2, 2, 2), ones);
    repeat (3) idle();
    drive(1'b1, 1'b1, 1'b0, 1'b1, pack(3, -1, 0, 5), pack(1, 4, 9, 2));
    repeat (4) idle();
    lit("bubbles", 1'b1, 17);
    drive(1'b1, 1'b1, 1'b1, 1'b1, pack(1, 2, 3, 4), ones);
    drive(1'b1, 1'b1, 1'b1, 1'b0, pack(1, 1, 1, 0), ones);
    drive(1'b1, 1'b1, 1'b0, 1'b1, ones, ones);
    repeat (2) idle();
    lit("b2b_a", 1'b1, 10);
    repeat (2) idle();
    lit("b2b_b", 1'b1, 7);
    drive(1'b1, 1'b1, 1'b1, 1'b0, pack(9, 9, 9, 9), ones);
    drive(1'b0, 1'b1, 1'b0, 1'b1, ones, ones);
    repeat (6) idle();
    lit("mid_reset", 1'b0, 0);
    drive(1'b1, 1'b0, 1'b1, 1'b1, ones, ones);
    repeat (4) idle();
    lit("last_no_valid", 1'b0, 0);
    drive(1'b1, 1'b1, 1'b1, 1'b1, pack(1, 2, 3, 4), pack(5, 6, 7, 8));
    repeat (4) idle();
    lit("after_reset", 1'b1, 70);
    for (int i = 0; i < 2000; i++)
      drive(1'($urandom_range(0, 99) != 0), 1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 3) == 0),
            1'($urandom_range(0, 2) == 0), word_t'($urandom), word_t'($urandom));
    repeat (6) idle();
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
